// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the tile framebuffer: screen geometry in 8x8 tiles,
// framebuffer depth, address/colour widths, fill-rectangle coordinate widths
// and the fill-engine state encoding.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int COLS     = 80;
  localparam int ROWS     = 60;
  localparam int FB_DEPTH = COLS * ROWS;
  localparam int ADDR_W   = 13;
  localparam int PIX_W    = 12;
  localparam int X_W      = 7;
  localparam int Y_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIN  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/tile_ram.sv
// -----------------------------------------------------------------------------
// tile_ram
// DEPTH x WIDTH distributed RAM holding one colour per tile.
// Ports:
//   vga_clk       write clock
//   we/waddr/wdata synchronous write port; out-of-range addresses are dropped
//   raddr/rdata   asynchronous read port; out-of-range addresses read as zero
// Contents are never reset.
// -----------------------------------------------------------------------------
module tile_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int WIDTH = PIX_W,
  parameter int AW    = ADDR_W
) (
  input  logic             vga_clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store wdata at waddr on the rising edge.
  always_ff @(posedge vga_clk) begin
    if (we && (waddr < DEPTH_A)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: combinational lookup, guarded against addresses past the array.
  always_comb begin
    rdata = {WIDTH{1'b0}};
    if (raddr < DEPTH_A) begin
      rdata = mem_r[raddr];
    end else begin
      rdata = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/vga_tile_fb.sv
// -----------------------------------------------------------------------------
// vga_tile_fb
// Tile framebuffer feeding the VGA scan-out driver, with a CPU write port and
// a rectangle-fill engine that paints one tile per clock.
// Ports:
//   vga_clk, rst_n       clock, synchronous active-low reset
//   rd_addr/rd_en/rd_data scan-out read, same-cycle data, 0 when disabled/out of range
//   wr_req/wr_addr/wr_data/wr_ack  CPU single-tile write with one-cycle ack
//   fill_start, fill_x0/x1, fill_y0/y1, fill_color  fill command (inclusive bounds)
//   busy/done/err        fill in progress, completion pulse, rejected-command pulse
// -----------------------------------------------------------------------------
module vga_tile_fb #(
  parameter int COLS   = vga_pkg::COLS,
  parameter int ROWS   = vga_pkg::ROWS,
  parameter int PIX_W  = vga_pkg::PIX_W,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  input  logic              fill_start,
  input  logic [6:0]        fill_x0,
  input  logic [6:0]        fill_x1,
  input  logic [5:0]        fill_y0,
  input  logic [5:0]        fill_y1,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import vga_pkg::fill_state_e;
  import vga_pkg::IDLE;
  import vga_pkg::FILL;
  import vga_pkg::FIN;

  localparam int                FB_DEPTH = COLS * ROWS;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]        X_MAX    = 7'(COLS - 1);
  localparam logic [5:0]        Y_MAX    = 6'(ROWS - 1);

  fill_state_e       state_r;
  logic [6:0]        cx_r, x0_r, x1_r;
  logic [5:0]        cy_r, y1_r;
  logic [PIX_W-1:0]  color_r;
  logic [ADDR_W-1:0] waddr_r, row_step_r;
  logic              busy_r, done_r, err_r, wr_ack_r;

  logic              rect_ok_s, cpu_take_s, ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s, start_addr_s;
  logic [PIX_W-1:0]  ram_wdata_s, ram_rdata_s;

  // Command validation, first-tile address and CPU write acceptance.
  // Constant multiply by COLS reduces to shift-add; the fill loop itself only increments.
  always_comb begin
    rect_ok_s    = (fill_x0 <= fill_x1) && (fill_x1 <= X_MAX) &&
                   (fill_y0 <= fill_y1) && (fill_y1 <= Y_MAX);
    start_addr_s = ADDR_W'(fill_y0) * COLS_A + ADDR_W'(fill_x0);
    // A held request is not re-accepted in its own ack cycle.
    if ((state_r == IDLE) && wr_req && !fill_start && !wr_ack_r) begin
      cpu_take_s = 1'b1;
    end else begin
      cpu_take_s = 1'b0;
    end
  end

  // RAM write mux: fill engine owns the port while filling, else the CPU.
  // Gated by rst_n so a reset edge never commits a write.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_addr;
    ram_wdata_s = wr_data;
    if (state_r == FILL) begin
      ram_we_s    = rst_n;
      ram_waddr_s = waddr_r;
      ram_wdata_s = color_r;
    end else begin
      ram_we_s    = rst_n && cpu_take_s && (wr_addr < DEPTH_A);
      ram_waddr_s = wr_addr;
      ram_wdata_s = wr_data;
    end
  end

  // Scan-out gating: blank outside active video and past the last tile.
  always_comb begin
    rd_data = {PIX_W{1'b0}};
    if (rd_en && (rd_addr < DEPTH_A)) begin
      rd_data = ram_rdata_s;
    end else begin
      rd_data = {PIX_W{1'b0}};
    end
  end

  // Fill FSM, write acknowledge and status pulses.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      wr_ack_r   <= 1'b0;
      cx_r       <= 7'd0;
      x0_r       <= 7'd0;
      x1_r       <= 7'd0;
      cy_r       <= 6'd0;
      y1_r       <= 6'd0;
      color_r    <= {PIX_W{1'b0}};
      waddr_r    <= {ADDR_W{1'b0}};
      row_step_r <= {ADDR_W{1'b0}};
    end else begin
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      wr_ack_r <= cpu_take_s;
      case (state_r)
        IDLE: begin
          if (fill_start) begin
            if (rect_ok_s) begin
              x0_r       <= fill_x0;
              x1_r       <= fill_x1;
              y1_r       <= fill_y1;
              cx_r       <= fill_x0;
              cy_r       <= fill_y0;
              color_r    <= fill_color;
              waddr_r    <= start_addr_s;
              // Jump from the last tile of a row to the first of the next.
              row_step_r <= COLS_A - ADDR_W'(fill_x1 - fill_x0);
              busy_r     <= 1'b1;
              state_r    <= FILL;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        FILL: begin
          if (cx_r < x1_r) begin
            cx_r    <= cx_r + 7'd1;
            waddr_r <= waddr_r + ONE_A;
          end else if (cy_r < y1_r) begin
            cx_r    <= x0_r;
            cy_r    <= cy_r + 6'd1;
            waddr_r <= waddr_r + row_step_r;
          end else begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= FIN;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign wr_ack = wr_ack_r;

  tile_ram #(
    .DEPTH(FB_DEPTH),
    .WIDTH(PIX_W),
    .AW   (ADDR_W)
  ) u_ram (
    .vga_clk(vga_clk),
    .we     (ram_we_s),
    .waddr  (ram_waddr_s),
    .wdata  (ram_wdata_s),
    .raddr  (rd_addr),
    .rdata  (ram_rdata_s)
  );

endmodule

// File: tb/tb_vga_tile_fb.sv
// -----------------------------------------------------------------------------
// tb_vga_tile_fb
// Directed self-checking bench for vga_tile_fb. Inputs change and outputs are
// sampled on the falling edge; "cycle k" is the k-th falling edge after a
// command was driven.
// -----------------------------------------------------------------------------
module tb_vga_tile_fb;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic [12:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        fill_start;
  logic [6:0]  fill_x0, fill_x1;
  logic [5:0]  fill_y0, fill_y1;
  logic [11:0] fill_color;
  logic        busy, done, err;

  int checks = 0;
  int passes = 0;

  always #5 vga_clk = ~vga_clk;

  vga_tile_fb dut (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .fill_start(fill_start),
    .fill_x0   (fill_x0),
    .fill_x1   (fill_x1),
    .fill_y0   (fill_y0),
    .fill_y1   (fill_y1),
    .fill_color(fill_color),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic read_tile(input logic [12:0] a, input logic en, output logic [11:0] v);
    @(negedge vga_clk);
    rd_addr = a;
    rd_en   = en;
    #1;
    v     = rd_data;
    rd_en = 1'b0;
  endtask

  // Holds the request through the ack cycle, then samples for a second ack.
  task automatic cpu_write(input logic [12:0] a, input logic [11:0] d,
                           output int lat, output logic extra);
    @(negedge vga_clk);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    lat     = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clk);
      lat++;
      if (wr_ack) break;
    end
    @(negedge vga_clk);
    extra  = wr_ack;
    wr_req = 1'b0;
  endtask

  // Strobe a fill at cycle 0 and watch until done or the cycle limit.
  // With poke set, an invalid command is strobed at cycle 3 while busy.
  task automatic run_fill(input logic [6:0] x0, input logic [6:0] x1,
                          input logic [5:0] y0, input logic [5:0] y1,
                          input logic [11:0] c, input bit poke, input int limit,
                          output int busy_cnt, output int done_cyc, output int err_cnt);
    @(negedge vga_clk);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
    fill_start = 1'b1;
    busy_cnt = 0; done_cyc = 0; err_cnt = 0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge vga_clk);
      fill_start = poke && (cyc == 3);
      if (poke && (cyc == 3)) begin
        fill_x0 = 7'd10;
        fill_x1 = 7'd5;
      end
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    fill_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] v;
    rst_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    checks++; if (wr_ack !== 1'b0) $display("FAIL reset_wr_ack got %b want 0", wr_ack); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passes++;
    read_tile(13'd5, 1'b0, v);
    checks++; if (v !== 12'h000) $display("FAIL reset_rd_dis got %h want 000", v); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_write();
    int lat; logic extra; logic [11:0] v;
    cpu_write(13'd0, 12'hF00, lat, extra);
    checks++; if (lat !== 1) $display("FAIL wr0_lat got %0d want 1", lat); else passes++;
    checks++; if (extra !== 1'b0) $display("FAIL wr0_single_ack got %b want 0", extra); else passes++;
    cpu_write(13'd4799, 12'h0F0, lat, extra);
    checks++; if (lat !== 1) $display("FAIL wr4799_lat got %0d want 1", lat); else passes++;
    cpu_write(13'd4800, 12'hEEE, lat, extra);
    checks++; if (lat !== 1) $display("FAIL wr_oob_lat got %0d want 1", lat); else passes++;
    read_tile(13'd0, 1'b1, v);
    checks++; if (v !== 12'hF00) $display("FAIL rd0 got %h want F00", v); else passes++;
    read_tile(13'd4799, 1'b1, v);
    checks++; if (v !== 12'h0F0) $display("FAIL rd4799 got %h want 0F0", v); else passes++;
    read_tile(13'd0, 1'b0, v);
    checks++; if (v !== 12'h000) $display("FAIL rd0_dis got %h want 000", v); else passes++;
    read_tile(13'd4799, 1'b0, v);
    checks++; if (v !== 12'h000) $display("FAIL rd4799_dis got %h want 000", v); else passes++;
    read_tile(13'd4800, 1'b1, v);
    checks++; if (v !== 12'h000) $display("FAIL rd_oob got %h want 000", v); else passes++;
  endtask

  task automatic test_fill_rect();
    int lat, bc, dc, ec; logic extra; logic [11:0] v;
    logic [12:0] in_addr [6];
    in_addr = '{13'd82, 13'd83, 13'd84, 13'd162, 13'd163, 13'd164};
    cpu_write(13'd81, 12'h111, lat, extra);
    cpu_write(13'd85, 12'h222, lat, extra);
    cpu_write(13'd165, 12'h333, lat, extra);
    run_fill(7'd2, 7'd4, 6'd1, 6'd2, 12'h00F, 1'b1, 30, bc, dc, ec);
    checks++; if (bc !== 6) $display("FAIL rect_busy_cycles got %0d want 6", bc); else passes++;
    checks++; if (dc !== 7) $display("FAIL rect_done_cycle got %0d want 7", dc); else passes++;
    checks++; if (ec !== 0) $display("FAIL rect_err_while_busy got %0d want 0", ec); else passes++;
    @(negedge vga_clk);
    checks++; if (done !== 1'b0) $display("FAIL rect_done_width got %b want 0", done); else passes++;
    foreach (in_addr[i]) begin
      read_tile(in_addr[i], 1'b1, v);
      checks++; if (v !== 12'h00F) $display("FAIL rect_in_%0d got %h want 00F", in_addr[i], v); else passes++;
    end
    read_tile(13'd81, 1'b1, v);
    checks++; if (v !== 12'h111) $display("FAIL rect_out_81 got %h want 111", v); else passes++;
    read_tile(13'd85, 1'b1, v);
    checks++; if (v !== 12'h222) $display("FAIL rect_out_85 got %h want 222", v); else passes++;
    read_tile(13'd165, 1'b1, v);
    checks++; if (v !== 12'h333) $display("FAIL rect_out_165 got %h want 333", v); else passes++;
  endtask

  task automatic test_invalid_fill();
    int lat, bc, dc, ec; logic extra; logic [11:0] v;
    cpu_write(13'd10, 12'h1A1, lat, extra);
    cpu_write(13'd4720, 12'h9C9, lat, extra);
    run_fill(7'd10, 7'd5, 6'd0, 6'd0, 12'h555, 1'b0, 4, bc, dc, ec);
    checks++; if (ec !== 1) $display("FAIL inv_x_err got %0d want 1", ec); else passes++;
    checks++; if (bc !== 0) $display("FAIL inv_x_busy got %0d want 0", bc); else passes++;
    checks++; if (dc !== 0) $display("FAIL inv_x_done got %0d want 0", dc); else passes++;
    run_fill(7'd0, 7'd0, 6'd58, 6'd60, 12'h555, 1'b0, 4, bc, dc, ec);
    checks++; if (ec !== 1) $display("FAIL inv_y_err got %0d want 1", ec); else passes++;
    checks++; if (bc !== 0) $display("FAIL inv_y_busy got %0d want 0", bc); else passes++;
    read_tile(13'd10, 1'b1, v);
    checks++; if (v !== 12'h1A1) $display("FAIL inv_ram_10 got %h want 1A1", v); else passes++;
    read_tile(13'd4720, 1'b1, v);
    checks++; if (v !== 12'h9C9) $display("FAIL inv_ram_4720 got %h want 9C9", v); else passes++;
  endtask

  task automatic test_full_screen();
    int bc, dc, ec; logic [11:0] v;
    run_fill(7'd0, 7'd79, 6'd0, 6'd59, 12'hABC, 1'b0, 4900, bc, dc, ec);
    checks++; if (bc !== 4800) $display("FAIL full_busy_cycles got %0d want 4800", bc); else passes++;
    checks++; if (dc !== 4801) $display("FAIL full_done_cycle got %0d want 4801", dc); else passes++;
    read_tile(13'd0, 1'b1, v);
    checks++; if (v !== 12'hABC) $display("FAIL full_rd0 got %h want ABC", v); else passes++;
    read_tile(13'd4799, 1'b1, v);
    checks++; if (v !== 12'hABC) $display("FAIL full_rd4799 got %h want ABC", v); else passes++;
    read_tile(13'd2440, 1'b1, v);
    checks++; if (v !== 12'hABC) $display("FAIL full_rd2440 got %h want ABC", v); else passes++;
  endtask

  // 4-tile fill (cols 0-1, rows 10-11) strobed together with a CPU write to 801.
  task automatic test_fill_vs_write();
    int done_cyc, ack_cyc, ack_cnt; logic [11:0] v;
    @(negedge vga_clk);
    fill_x0 = 7'd0; fill_x1 = 7'd1; fill_y0 = 6'd10; fill_y1 = 6'd11; fill_color = 12'h5A5;
    fill_start = 1'b1;
    wr_req = 1'b1; wr_addr = 13'd801; wr_data = 12'h777;
    done_cyc = 0; ack_cyc = 0; ack_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge vga_clk);
      fill_start = 1'b0;
      if (done) done_cyc = cyc;
      if (wr_ack) begin
        ack_cnt++;
        if (ack_cyc == 0) ack_cyc = cyc;
      end
      if ((ack_cyc != 0) && (cyc > ack_cyc)) wr_req = 1'b0;
    end
    wr_req = 1'b0;
    checks++; if (done_cyc !== 5) $display("FAIL arb_done_cycle got %0d want 5", done_cyc); else passes++;
    checks++; if (ack_cyc !== 7) $display("FAIL arb_ack_cycle got %0d want 7", ack_cyc); else passes++;
    checks++; if (ack_cnt !== 1) $display("FAIL arb_ack_count got %0d want 1", ack_cnt); else passes++;
    read_tile(13'd801, 1'b1, v);
    checks++; if (v !== 12'h777) $display("FAIL arb_rd801 got %h want 777", v); else passes++;
    read_tile(13'd800, 1'b1, v);
    checks++; if (v !== 12'h5A5) $display("FAIL arb_rd800 got %h want 5A5", v); else passes++;
    read_tile(13'd881, 1'b1, v);
    checks++; if (v !== 12'h5A5) $display("FAIL arb_rd881 got %h want 5A5", v); else passes++;
  endtask

  // 10-tile fill of row 30, cols 20-29 (addr 2420..2429), reset in cycle 3.
  task automatic test_reset_mid_fill();
    int bc, dc, ec, late_done; logic [11:0] v;
    @(negedge vga_clk);
    fill_x0 = 7'd20; fill_x1 = 7'd29; fill_y0 = 6'd30; fill_y1 = 6'd30; fill_color = 12'h123;
    fill_start = 1'b1;
    @(negedge vga_clk);
    fill_start = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy); else passes++;
    rst_n = 1'b0;
    @(negedge vga_clk);
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after got %b want 0", busy); else passes++;
    rst_n = 1'b1;
    late_done = 0;
    repeat (12) begin
      @(negedge vga_clk);
      if (done) late_done++;
    end
    checks++; if (late_done !== 0) $display("FAIL rstmid_no_done got %0d want 0", late_done); else passes++;
    read_tile(13'd2420, 1'b1, v);
    checks++; if (v !== 12'h123) $display("FAIL rstmid_rd2420 got %h want 123", v); else passes++;
    read_tile(13'd2421, 1'b1, v);
    checks++; if (v !== 12'h123) $display("FAIL rstmid_rd2421 got %h want 123", v); else passes++;
    read_tile(13'd2422, 1'b1, v);
    checks++; if (v !== 12'hABC) $display("FAIL rstmid_rd2422 got %h want ABC", v); else passes++;
    read_tile(13'd2429, 1'b1, v);
    checks++; if (v !== 12'hABC) $display("FAIL rstmid_rd2429 got %h want ABC", v); else passes++;
    run_fill(7'd20, 7'd29, 6'd30, 6'd30, 12'h456, 1'b0, 30, bc, dc, ec);
    checks++; if (bc !== 10) $display("FAIL refill_busy_cycles got %0d want 10", bc); else passes++;
    checks++; if (dc !== 11) $display("FAIL refill_done_cycle got %0d want 11", dc); else passes++;
    read_tile(13'd2425, 1'b1, v);
    checks++; if (v !== 12'h456) $display("FAIL refill_rd2425 got %h want 456", v); else passes++;
    read_tile(13'd2430, 1'b1, v);
    checks++; if (v !== 12'hABC) $display("FAIL refill_rd2430 got %h want ABC", v); else passes++;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = 13'd0; rd_en = 1'b0;
    wr_req = 1'b0; wr_addr = 13'd0; wr_data = 12'h000;
    fill_start = 1'b0; fill_x0 = 7'd0; fill_x1 = 7'd0;
    fill_y0 = 6'd0; fill_y1 = 6'd0; fill_color = 12'h000;
    test_reset();
    test_cpu_write();
    test_fill_rect();
    test_invalid_fill();
    test_full_screen();
    test_fill_vs_write();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_tile_fb.md
# vga_tile_fb

Tile framebuffer that sits directly upstream of the VGA scan-out driver: stores one 12-bit RGB colour per 8×8-pixel tile (80×60 tiles) and serves the driver's combinational read address with same-cycle data. CPU-side writes arrive through a single-word request/acknowledge port. A built-in rectangle-fill engine paints a tile region with one colour, one tile per clock, without CPU involvement.

## Interface
Parameters:
- COLS, 80, tiles per row
- ROWS, 60, tile rows
- PIX_W, 12, colour width (rrrr gggg bbbb)
- ADDR_W, 13, tile address width

Ports:
- vga_clk  in  1  single clock (25 MHz), all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- rd_addr  in  ADDR_W  scan-out tile address (row*COLS+col)
- rd_en  in  1  scan-out read enable (driver's active-video flag)
- rd_data  out  PIX_W  colour at rd_addr, combinational; 0 when rd_en=0 or rd_addr≥COLS*ROWS
- wr_req  in  1  CPU single-tile write request
- wr_addr  in  ADDR_W  CPU write address
- wr_data  in  PIX_W  CPU write colour
- wr_ack  out  1  one-cycle write acknowledge
- fill_start  in  1  one-cycle fill command strobe
- fill_x0, fill_x1  in  7  inclusive column bounds
- fill_y0, fill_y1  in  6  inclusive row bounds
- fill_color  in  PIX_W  fill colour
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse at fill completion
- err  out  1  one-cycle pulse when a fill command is rejected

## Operation
- Storage: COLS*ROWS = 4800 words × PIX_W; contents not cleared by reset, undefined after power-up.
- FSM states: IDLE, FILL, FIN.
- IDLE: fill_start with valid rect (x0≤x1≤COLS-1, y0≤y1≤ROWS-1) latches bounds and colour, sets cx=x0, cy=y0, waddr=y0*COLS+x0, goes to FILL. Invalid rect: err pulses next cycle, stays IDLE, RAM untouched.
- FILL: each cycle writes fill_color to waddr. If cx<x1: cx+1, waddr+1. Else if cy<y1: cx=x0, cy+1, waddr += COLS-(x1-x0). Else go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- waddr uses an incremental adder only; no multiplier in the fill path. Width ADDR_W, never exceeds 4799.
- CPU writes: accepted only in IDLE with no fill_start that same cycle. The write happens at the edge; wr_ack=1 the following cycle. wr_req is held by the master until ack. At most one ack per request cycle. The master drops wr_req the cycle after ack or issues the next write.
- wr_addr≥4800: acked, no write.
- Simultaneous wr_req and fill_start in IDLE: fill wins, wr_req is stalled until FIN completes.
- fill_start while busy: ignored, no err.
- Read port is independent of the FSM. A read of an address written in the same cycle returns old data.
- Reset mid-fill: FSM→IDLE, busy/done/err/wr_ack→0 on that edge. Tiles already written keep their new colour.

## Timing
- Reset values: wr_ack=0, busy=0, done=0, err=0, state=IDLE. rd_data follows its combinational rule.
- rd_data latency: 0 cycles (asynchronous read), so the driver's registered RGB stage captures it at the next edge.
- Fill of N=(x1-x0+1)(y1-y0+1) tiles: busy rises 1 cycle after fill_start and stays high N cycles. done pulses the cycle after the last write. Total from strobe to done is N+1 cycles.
- CPU write: request-to-ack latency 1 cycle when IDLE. While busy, latency is up to N+2 cycles.

## Structure
- Shared package vga_pkg: COLS, ROWS, FB_DEPTH=4800, ADDR_W, PIX_W, FSM state encoding.
- Sub-module tile_ram: FB_DEPTH×PIX_W, one synchronous write port, one asynchronous read port (distributed RAM). The top level holds the FSM, the write arbiter and the read gating.

## Test plan
- Reset then CPU write 0xF00 to addr 0 and 0x0F0 to 4799 -> wr_ack 1 cycle after each request. rd_addr=0/4799 with rd_en=1 return 0xF00/0x0F0; with rd_en=0 they return 0.
- fill (x0=2,x1=4,y0=1,y1=2,0x00F) -> busy high exactly 6 cycles, done 7 cycles after strobe. Addr 82..84 and 162..164 read 0x00F; addr 81, 85 and 165 are unchanged.
- Full-screen fill 0..79 × 0..59 with 0xABC -> 4800 busy cycles, done at cycle 4801, corner addr 0 and 4799 read 0xABC.
- Invalid fill x0=10,x1=5, then y1=60 -> err pulses 1 cycle each, busy stays 0, RAM unchanged.
- wr_req asserted in the same cycle as a 4-tile fill_start -> fill completes first. wr_ack comes 1 cycle after FIN, and the written tile holds the CPU data.
- Reset asserted at the 3rd cycle of a 10-tile fill -> next cycle busy=0, no done pulse. First 2 tiles are filled, the remaining tiles are untouched. A new fill then runs normally.
